clock_display_driver: RTL and testbench

- Downstream consumer of the time-keeping block's 11-bit display bus {AM_PM, HOURS[3:0], MINUTES[5:0]}.
- Converts binary hours (1..12) and minutes (0..59) to four BCD digits.
- Drives a time-multiplexed, common-select 4-digit seven-segment display, plus an AM/PM LED and a colon LED.
- Sits between the time block and the board-level LED/segment pins.

---
 rtl/clock_display_driver.sv | 159 +++++++++++++++
 tb/tb_clock_display_driver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/clock_display_driver.sv
// Scans the time bus as four seven-segment digits plus AM/PM and colon LEDs.
// Optional macro COLON_BLINK_EN makes the colon blink every BLINK_FRAMES frames.
module clock_display_driver #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [10:0] display_bus_i,
  output logic [6:0]  seg_o,
  output logic [3:0]  dig_sel_o,
  output logic        am_pm_led_o,
  output logic        colon_o
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);

  logic [PreW-1:0] prescaler_q, prescaler_d;
  logic [1:0]      digitIdx_q, digitIdx_d;
  logic [10:0]     snapshot_q, snapshot_d;
  logic [6:0]      seg_d;
  logic [3:0]      digSel_d;
  logic            amPm_d;
  logic            colon_d;
  logic            preTerm;
  logic            frameWrap;

  logic [3:0] hours;
  logic [5:0] minutes;
  logic       invalid;
  logic       hrTens;
  logic [3:0] hrOnes;
  logic [2:0] minTens;
  logic [3:0] minOnes;
  logic [6:0] digitSeg;

  function automatic logic [6:0] segOf(input logic [3:0] digit);
    case (digit)
      4'd0:    segOf = 7'h3F;
      4'd1:    segOf = 7'h06;
      4'd2:    segOf = 7'h5B;
      4'd3:    segOf = 7'h4F;
      4'd4:    segOf = 7'h66;
      4'd5:    segOf = 7'h6D;
      4'd6:    segOf = 7'h7D;
      4'd7:    segOf = 7'h07;
      4'd8:    segOf = 7'h7F;
      4'd9:    segOf = 7'h6F;
      default: segOf = 7'h00;
    endcase
  endfunction

  // The snapshot only reloads at a frame boundary, so one frame never mixes two bus values.
  always_comb begin
    preTerm     = enable_i && (prescaler_q == PreLast);
    frameWrap   = preTerm && (digitIdx_q == 2'd3);
    prescaler_d = '0;
    digitIdx_d  = '0;
    snapshot_d  = display_bus_i;
    if (enable_i) begin
      prescaler_d = preTerm ? '0 : prescaler_q + PreW'(1);
      digitIdx_d  = preTerm ? digitIdx_q + 2'd1 : digitIdx_q;
      snapshot_d  = frameWrap ? display_bus_i : snapshot_q;
    end
  end

  always_comb begin
    hours   = snapshot_q[9:6];
    minutes = snapshot_q[5:0];
    invalid = (hours == 4'd0) || (hours > 4'd12) || (minutes > 6'd59);
    hrTens  = (hours >= 4'd10);
    hrOnes  = hrTens ? hours - 4'd10 : hours;
    if (minutes >= 6'd50)      minTens = 3'd5;
    else if (minutes >= 6'd40) minTens = 3'd4;
    else if (minutes >= 6'd30) minTens = 3'd3;
    else if (minutes >= 6'd20) minTens = 3'd2;
    else if (minutes >= 6'd10) minTens = 3'd1;
    else                       minTens = 3'd0;
    minOnes = 4'(minutes - 6'(minTens) * 6'd10);
    case (digitIdx_q)
      2'd0:    digitSeg = segOf(minOnes);
      2'd1:    digitSeg = segOf({1'b0, minTens});
      2'd2:    digitSeg = segOf(hrOnes);
      default: digitSeg = hrTens ? 7'h06 : 7'h00;
    endcase
    if (invalid) digitSeg = 7'h40;
  end

  always_comb begin
    seg_d    = '0;
    digSel_d = '0;
    amPm_d   = 1'b0;
    if (enable_i) begin
      seg_d    = digitSeg;
      digSel_d = 4'b0001 << digitIdx_q;
      amPm_d   = snapshot_q[10];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescaler_q <= '0;
      digitIdx_q  <= '0;
      snapshot_q  <= '0;
      seg_o       <= '0;
      dig_sel_o   <= '0;
      am_pm_led_o <= 1'b0;
      colon_o     <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      digitIdx_q  <= digitIdx_d;
      snapshot_q  <= snapshot_d;
      seg_o       <= seg_d;
      dig_sel_o   <= digSel_d;
      am_pm_led_o <= amPm_d;
      colon_o     <= colon_d;
    end
  end

`ifdef COLON_BLINK_EN
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  logic [FrameW-1:0] frameCnt_q, frameCnt_d;
  logic              colonOff_q, colonOff_d;
  logic              blinkTerm;

  // colonOff is cleared while disabled so the colon always comes back lit.
  always_comb begin
    blinkTerm  = frameWrap && (frameCnt_q == FrameLast);
    frameCnt_d = '0;
    colonOff_d = 1'b0;
    if (enable_i) begin
      frameCnt_d = frameCnt_q;
      colonOff_d = colonOff_q;
      if (frameWrap) begin
        frameCnt_d = blinkTerm ? '0 : frameCnt_q + FrameW'(1);
        colonOff_d = colonOff_q ^ blinkTerm;
      end
    end
    colon_d = enable_i & ~colonOff_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frameCnt_q <= '0;
      colonOff_q <= 1'b0;
    end else begin
      frameCnt_q <= frameCnt_d;
      colonOff_q <= colonOff_d;
    end
  end
`else
  assign colon_d = enable_i & (BLINK_FRAMES > 0);
`endif

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed self-checking bench for clock_display_driver with SCAN_DIV=4, BLINK_FRAMES=2.
// Expected segment codes and scan timing are hand-computed per frame.
module tb_clock_display_driver;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [10:0] displayBus;
  logic [6:0]  seg;
  logic [3:0]  digSel;
  logic        amPmLed;
  logic        colon;

  int assertCount;
  int failCount;

  clock_display_driver #(
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .enable_i     (enable),
    .display_bus_i(displayBus),
    .seg_o        (seg),
    .dig_sel_o    (digSel),
    .am_pm_led_o  (amPmLed),
    .colon_o      (colon)
  );

  // Free-running 10 ns clock; outputs are sampled on the falling edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [10:0] mkBus(input logic pm, input int h, input int m);
    mkBus = {pm, 4'(h), 6'(m)};
  endfunction

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [10:0] bus);
    enable     = en;
    displayBus = bus;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Walks one 16-cycle frame, checking scan position, segment code and AM/PM on every cycle.
  // A new bus value can be applied mid-frame at cycle changeAt; it must not appear until the next frame.
  task automatic checkFrame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic am,
                            input int changeAt, input logic [10:0] newBus);
    logic [6:0] expSeg;
    logic [3:0] expDig;
    for (int k = 0; k < 16; k++) begin
      if (k == changeAt) applyStimulus(1'b1, newBus);
      tick();
      expDig = 4'b0001 << (k / 4);
      case (k / 4)
        0:       expSeg = s0;
        1:       expSeg = s1;
        2:       expSeg = s2;
        default: expSeg = s3;
      endcase
      checkOutput($sformatf("%s dig k%0d", tag, k), 32'(digSel), 32'(expDig));
      checkOutput($sformatf("%s seg k%0d", tag, k), 32'(seg), 32'(expSeg));
      checkOutput($sformatf("%s ampm k%0d", tag, k), 32'(amPmLed), 32'(am));
`ifndef COLON_BLINK_EN
      checkOutput($sformatf("%s colon k%0d", tag, k), 32'(colon), 32'd1);
`endif
    end
  endtask

  task automatic checkBlank(input string tag);
    checkOutput({tag, " seg"}, 32'(seg), 32'd0);
    checkOutput({tag, " dig"}, 32'(digSel), 32'd0);
    checkOutput({tag, " ampm"}, 32'(amPmLed), 32'd0);
    checkOutput({tag, " colon"}, 32'(colon), 32'd0);
  endtask

  initial begin
    logic expColon;
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b0;
    applyStimulus(1'b0, 11'd0);
    #1 reset = 1'b1;
    #1 checkBlank("reset");

    // One disabled cycle loads 12:00 AM into the snapshot before scanning starts.
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, mkBus(1'b0, 12, 0));
    tick();
    checkBlank("disabled");
    applyStimulus(1'b1, mkBus(1'b0, 12, 0));

    checkFrame("f1 12:00",  7'h3F, 7'h3F, 7'h5B, 7'h06, 1'b0, 5, mkBus(1'b1, 9, 5));
    checkFrame("f2 9:05pm", 7'h6D, 7'h3F, 7'h6F, 7'h00, 1'b1, 6, mkBus(1'b0, 0, 30));
    checkFrame("f3 h0",     7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 5, mkBus(1'b1, 13, 0));
    checkFrame("f4 h13",    7'h40, 7'h40, 7'h40, 7'h40, 1'b1, 5, mkBus(1'b0, 5, 60));
    checkFrame("f5 m60",    7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 5, mkBus(1'b0, 12, 0));
    checkFrame("f6 12:00",  7'h3F, 7'h3F, 7'h5B, 7'h06, 1'b0, 5, mkBus(1'b1, 1, 59));
    checkFrame("f7 1:59pm", 7'h6F, 7'h6D, 7'h06, 7'h00, 1'b1, -1, 11'd0);

    // Disable while digit 1 is lit, then re-enable with a new time.
    repeat (5) tick();
    checkOutput("mid dig", 32'(digSel), 32'h2);
    checkOutput("mid seg", 32'(seg), 32'h6D);
    applyStimulus(1'b0, mkBus(1'b1, 3, 7));
    tick();
    checkBlank("disable");
    tick();
    applyStimulus(1'b1, mkBus(1'b1, 3, 7));
    checkFrame("f8 3:07pm", 7'h07, 7'h3F, 7'h4F, 7'h00, 1'b1, -1, 11'd0);

    // Asynchronous reset between clock edges clears outputs at once and zeroes the snapshot.
    repeat (5) tick();
    checkOutput("prerst dig", 32'(digSel), 32'h2);
    #1 reset = 1'b1;
    #1 checkBlank("async rst");
    #1 reset = 1'b0;
    checkFrame("f9 zero",   7'h40, 7'h40, 7'h40, 7'h40, 1'b0, -1, 11'd0);
    checkFrame("f10 3:07pm", 7'h07, 7'h3F, 7'h4F, 7'h00, 1'b1, -1, 11'd0);

    // Colon: steady on by default; with blinking, two 16-cycle frames per phase.
    applyStimulus(1'b0, mkBus(1'b0, 12, 0));
    tick();
    applyStimulus(1'b1, mkBus(1'b0, 12, 0));
    for (int k = 0; k < 96; k++) begin
      tick();
`ifdef COLON_BLINK_EN
      expColon = ((k / 32) % 2) == 0;
`else
      expColon = 1'b1;
`endif
      checkOutput($sformatf("colon k%0d", k), 32'(colon), 32'(expColon));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
